// File: rtl/brick_collider_if.sv
// Bus between the brick collider and its neighbours (ball mover, renderer,
// score accumulator).
//   frame_tick   : one-cycle pulse per video frame, starts a collision scan
//   ball_x/y     : ball top-left coordinates
//   lose         : ball lost, restore every brick and abort any scan
//   collide      : one-hot, one-cycle hit strobe (bit i = brick i)
//   bounce_x/y   : one-cycle velocity-reversal requests to the ball mover
//   bricks_alive : per-brick presence, 1 = still standing
//   all_cleared  : level, no bricks left
//   busy         : a scan is in progress
// The master modport is the side that drives the frame/ball/lose inputs;
// the slave modport is the collider itself.
interface brick_collider_if #(
    parameter int NUM_BRICKS = 15,
    parameter int CW         = 10
);
    logic                  frame_tick;
    logic [CW-1:0]         ball_x;
    logic [CW-1:0]         ball_y;
    logic                  lose;
    logic [NUM_BRICKS-1:0] collide;
    logic                  bounce_x;
    logic                  bounce_y;
    logic [NUM_BRICKS-1:0] bricks_alive;
    logic                  all_cleared;
    logic                  busy;

    modport master (
        output frame_tick, ball_x, ball_y, lose,
        input  collide, bounce_x, bounce_y, bricks_alive, all_cleared, busy
    );

    modport slave (
        input  frame_tick, ball_x, ball_y, lose,
        output collide, bounce_x, bounce_y, bricks_alive, all_cleared, busy
    );
endinterface

// File: rtl/brick_collider.sv
// Brick collider: keeps alive/dead state for a grid of bricks and, once per
// frame, scans the live bricks one per cycle against a latched copy of the
// ball position. The first (lowest-index) overlapping live brick is killed,
// a one-cycle one-hot collide strobe is produced and exactly one bounce
// request is issued.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : brick_collider_if.slave (frame_tick, ball_x/y, lose in;
//          collide, bounce_x/y, bricks_alive, all_cleared, busy out)
module brick_collider #(
    parameter int NUM_BRICKS = 15,
    parameter int COLS       = 5,
    parameter int ORIGIN_X   = 40,
    parameter int ORIGIN_Y   = 40,
    parameter int BRICK_W    = 40,
    parameter int BRICK_H    = 16,
    parameter int GAP        = 4,
    parameter int BALL_SIZE  = 8,
    parameter int CW         = 10
) (
    input  logic               clk,
    input  logic               rst,
    brick_collider_if.slave    bus
);
    localparam int XW  = CW + 1;
    localparam int IW  = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, HIT} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CLW-1:0]        col_q, col_d;
    logic [XW-1:0]         x0_q, x0_d;
    logic [XW-1:0]         y0_q, y0_d;
    logic [CW-1:0]         bx_q, bx_d;
    logic [CW-1:0]         by_q, by_d;
    logic                  hit_y_q, hit_y_d;
    logic [NUM_BRICKS-1:0] collide_q, collide_d;
    logic                  bounce_x_q, bounce_x_d;
    logic                  bounce_y_q, bounce_y_d;
    logic [NUM_BRICKS-1:0] alive_q, alive_d;
    logic                  busy_q, busy_d;

    // Overlap test in CW+1 bits so ball_x+BALL_SIZE and x0+BRICK_W never wrap.
    logic [XW-1:0] bx_w, by_w, cx_w;
    logic          ovl_x, ovl_y, center_in_x, cur_alive;

    always_comb begin
        bx_w        = {1'b0, bx_q};
        by_w        = {1'b0, by_q};
        cx_w        = bx_w + XW'(BALL_SIZE / 2);
        ovl_x       = ((bx_w + XW'(BALL_SIZE)) > x0_q) && (bx_w < (x0_q + XW'(BRICK_W)));
        ovl_y       = ((by_w + XW'(BALL_SIZE)) > y0_q) && (by_w < (y0_q + XW'(BRICK_H)));
        // Ball centre inside the brick's x span means it struck a top/bottom face.
        center_in_x = (cx_w >= x0_q) && (cx_w < (x0_q + XW'(BRICK_W)));
        cur_alive   = alive_q[idx_q];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        col_d      = col_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        bx_d       = bx_q;
        by_d       = by_q;
        hit_y_d    = hit_y_q;
        alive_d    = alive_q;
        busy_d     = busy_q;
        collide_d  = '0;
        bounce_x_d = 1'b0;
        bounce_y_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.frame_tick) begin
                    bx_d    = bus.ball_x;
                    by_d    = bus.ball_y;
                    idx_d   = '0;
                    col_d   = '0;
                    x0_d    = XW'(ORIGIN_X);
                    y0_d    = XW'(ORIGIN_Y);
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cur_alive && ovl_x && ovl_y) begin
                    hit_y_d = center_in_x;
                    state_d = HIT;
                end else if (idx_q == IW'(NUM_BRICKS - 1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    // Walk the grid with counters instead of dividing idx.
                    idx_d = idx_q + 1'b1;
                    if (col_q == CLW'(COLS - 1)) begin
                        col_d = '0;
                        x0_d  = XW'(ORIGIN_X);
                        y0_d  = y0_q + XW'(BRICK_H + GAP);
                    end else begin
                        col_d = col_q + 1'b1;
                        x0_d  = x0_q + XW'(BRICK_W + GAP);
                    end
                end
            end
            HIT: begin
                collide_d      = NUM_BRICKS'(1) << idx_q;
                alive_d[idx_q] = 1'b0;
                bounce_y_d     = hit_y_q;
                bounce_x_d     = ~hit_y_q;
                busy_d         = 1'b0;
                state_d        = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // lose overrides everything, including a pending HIT and a new frame.
        if (bus.lose) begin
            alive_d    = '1;
            collide_d  = '0;
            bounce_x_d = 1'b0;
            bounce_y_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            col_q      <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            hit_y_q    <= 1'b0;
            collide_q  <= '0;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
            alive_q    <= '1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            col_q      <= col_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            hit_y_q    <= hit_y_d;
            collide_q  <= collide_d;
            bounce_x_q <= bounce_x_d;
            bounce_y_q <= bounce_y_d;
            alive_q    <= alive_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.collide      = collide_q;
    assign bus.bounce_x     = bounce_x_q;
    assign bus.bounce_y     = bounce_y_q;
    assign bus.bricks_alive = alive_q;
    assign bus.all_cleared  = ~|alive_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_brick_collider.sv
// Self-checking bench for brick_collider: directed frames from the test plan
// followed by randomized frames, all checked against a geometric model.
module tb_brick_collider;
    localparam int NB   = 15;
    localparam int COLS = 5;
    localparam int OX   = 40;
    localparam int OY   = 40;
    localparam int BW   = 40;
    localparam int BH   = 16;
    localparam int GAP  = 4;
    localparam int BS   = 8;
    localparam int CW   = 10;

    logic clk;
    logic rst;

    brick_collider_if #(.NUM_BRICKS(NB), .CW(CW)) bif ();

    brick_collider #(
        .NUM_BRICKS(NB), .COLS(COLS), .ORIGIN_X(OX), .ORIGIN_Y(OY),
        .BRICK_W(BW), .BRICK_H(BH), .GAP(GAP), .BALL_SIZE(BS), .CW(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit [NB-1:0] alive_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int brick_x0(int i);
        return OX + (i % COLS) * (BW + GAP);
    endfunction

    function automatic int brick_y0(int i);
        return OY + (i / COLS) * (BH + GAP);
    endfunction

    // Lowest-index live brick overlapping the ball, or -1; hit_y reports
    // whether the ball centre lies inside that brick's x span.
    function automatic int model_hit(int bx, int by, output bit hit_y);
        hit_y = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (alive_m[i]) begin
                int x0 = brick_x0(i);
                int y0 = brick_y0(i);
                if (bx + BS > x0 && bx < x0 + BW && by + BS > y0 && by < y0 + BH) begin
                    hit_y = (bx + BS / 2 >= x0) && (bx + BS / 2 < x0 + BW);
                    return i;
                end
            end
        end
        return -1;
    endfunction

    // One frame: tick at edge E0, then observe 17 cycles. With jitter the
    // ball inputs change and stray ticks arrive mid-scan; both must be
    // ignored. With lose_in_hit, lose is sampled on the edge ending HIT.
    task automatic run_frame(input int bx, input int by, input bit jitter, input bit lose_in_hit);
        int  k;
        int  end_c;
        bit  hy;
        bit  do_lose;
        logic [NB-1:0] exp_col;
        k       = model_hit(bx, by, hy);
        do_lose = lose_in_hit && (k >= 0);
        end_c   = (k >= 0) ? k + 2 : NB;
        bif.ball_x     = CW'(bx);
        bif.ball_y     = CW'(by);
        bif.frame_tick = 1'b1;
        step();
        bif.frame_tick = 1'b0;
        chk("busy_start", 32'(bif.busy), 32'd1);
        for (int c = 1; c <= 17; c++) begin
            if (jitter) begin
                bif.ball_x = CW'($urandom_range(0, 1023));
                bif.ball_y = CW'($urandom_range(0, 1023));
                if (c < end_c - 1 && $urandom_range(0, 2) == 0) bif.frame_tick = 1'b1;
            end
            if (do_lose && c == end_c) bif.lose = 1'b1;
            step();
            bif.frame_tick = 1'b0;
            bif.lose       = 1'b0;
            exp_col = '0;
            if (k >= 0 && !do_lose && c == end_c) exp_col = NB'(1) << k;
            chk("collide", 32'(bif.collide), 32'(exp_col));
            chk("bounce_x", 32'(bif.bounce_x), 32'(k >= 0 && !do_lose && c == end_c && !hy));
            chk("bounce_y", 32'(bif.bounce_y), 32'(k >= 0 && !do_lose && c == end_c && hy));
            chk("busy", 32'(bif.busy), 32'(c < end_c));
        end
        if (do_lose) alive_m = '1;
        else if (k >= 0) alive_m[k] = 1'b0;
        chk("alive", 32'(bif.bricks_alive), 32'(alive_m));
        chk("all_cleared", 32'(bif.all_cleared), 32'(alive_m == '0));
        $display("frame ball=(%0d,%0d) hit=%0d bounce_y=%0b lose_in_hit=%0b alive=%h",
                 bx, by, k, hy, do_lose, alive_m);
    endtask

    task automatic lose_pulse();
        bif.lose = 1'b1;
        step();
        bif.lose = 1'b0;
        alive_m  = '1;
        chk("lose_alive", 32'(bif.bricks_alive), 32'(alive_m));
        chk("lose_cleared", 32'(bif.all_cleared), 32'd0);
        chk("lose_busy", 32'(bif.busy), 32'd0);
        $display("lose alive=%h", alive_m);
    endtask

    task automatic aim(input int j, output int bx, output int by);
        bx = brick_x0(j) + $urandom_range(0, BW + BS - 2) - (BS - 1);
        by = brick_y0(j) + $urandom_range(0, BH + BS - 2) - (BS - 1);
    endtask

    initial begin
        int bx, by;
        rst = 1'b1;
        bif.frame_tick = 1'b0;
        bif.lose       = 1'b0;
        bif.ball_x     = '0;
        bif.ball_y     = '0;
        alive_m        = '1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_alive", 32'(bif.bricks_alive), 32'h7FFF);
        chk("rst_collide", 32'(bif.collide), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_cleared", 32'(bif.all_cleared), 32'd0);
        chk("rst_bounce", 32'({bif.bounce_x, bif.bounce_y}), 32'd0);

        // Directed frames from the test plan.
        run_frame(50, 50, 0, 0);
        run_frame(50, 50, 0, 0);
        run_frame(140, 64, 0, 0);
        lose_pulse();
        run_frame(78, 44, 0, 0);
        run_frame(78, 44, 0, 0);
        lose_pulse();

        // Clear the whole field, then scan an empty field.
        for (int j = 0; j < NB; j++)
            run_frame(brick_x0(j) + 16, brick_y0(j) + 4, 0, 0);
        chk("cleared_level", 32'(bif.all_cleared), 32'd1);
        run_frame(50, 50, 0, 0);
        lose_pulse();

        // lose during HIT, and a noisy frame with mid-scan ticks/ball moves.
        run_frame(50, 50, 0, 1);
        aim(12, bx, by);
        run_frame(bx, by, 1, 0);

        // lose and frame_tick on the same edge: no scan starts.
        bif.lose       = 1'b1;
        bif.frame_tick = 1'b1;
        bif.ball_x     = CW'(50);
        bif.ball_y     = CW'(50);
        step();
        bif.lose       = 1'b0;
        bif.frame_tick = 1'b0;
        alive_m        = '1;
        chk("lose_tick_busy", 32'(bif.busy), 32'd0);
        chk("lose_tick_alive", 32'(bif.bricks_alive), 32'h7FFF);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("lose_tick_collide", 32'(bif.collide), 32'd0);
            chk("lose_tick_busy2", 32'(bif.busy), 32'd0);
        end
        $display("lose+tick same edge checked");

        // Randomized frames.
        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bx = $urandom_range(0, 300);
                by = $urandom_range(0, 130);
            end else begin
                aim($urandom_range(0, NB - 1), bx, by);
            end
            run_frame(bx, by, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            if (alive_m == '0 || $urandom_range(0, 15) == 0) lose_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
